// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_pkg
// Purpose  : Shared encodings and helpers for the rv32e data-side memory
//            bridge: access size codes, bridge FSM state type, byte-lane
//            write-enable generation and write-data lane replication.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

    // Access size field, cpu_data_mode_in[1:0]. Code 2'b11 is reserved and
    // is decoded everywhere as a word access.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Little-endian byte-lane enables for a write of the given size.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Copy the low-order write data into every lane it could land in, so
    // the lane enables alone decide which bytes the RAM takes.
    function automatic logic [31:0] replicate(input logic [1:0]  size,
                                              input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational read-data extraction. Selects the byte or
//            half-word lane addressed by addr_lo out of a RAM word and
//            sign- or zero-extends it to 32 bits.
// Ports    : word        - raw 32-bit RAM read word
//            size        - access size code (SZ_BYTE/SZ_HALF/word)
//            addr_lo     - byte address bits [1:0] of the access
//            is_unsigned - 1 = zero-extend, 0 = sign-extend
//            result      - aligned, extended load value
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        w_half = word[15:0];
        result = word;

        case (addr_lo)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase

        if (addr_lo[1]) begin
            w_half = word[31:16];
        end

        case (size)
            SZ_BYTE: result = is_unsigned ? {24'h000000, w_byte}
                                          : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: result = is_unsigned ? {16'h0000, w_half}
                                          : {{16{w_half[15]}}, w_half};
            default: result = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_bridge_rv32e.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_rv32e
// Purpose  : Data-side bridge between the rv32e core and a synchronous
//            single-port scratchpad RAM. Accepts one core access per
//            unstalled cycle, issues it to the RAM for one cycle, holds the
//            core stalled for 1+WAIT_STATES cycles and returns aligned,
//            extended read data. Misaligned or out-of-range accesses are
//            suppressed and raise a sticky error flag.
// Ports    : clock, reset (async, active low)
//            cpu_addr_in/cpu_data_in/cpu_wb_in/cpu_data_mode_in - core access
//            cpu_data_out, cpu_stall_out                        - to core
//            mem_en_out/mem_wb_out/mem_addr_out/mem_data_out    - to RAM
//            mem_data_in                                        - from RAM
//            err_out                                            - sticky error
// Revision : 1.0 - initial release
// ============================================================================
module mem_bridge_rv32e
    import mem_bridge_pkg::*;
#(
    parameter int MEMORY_WIDTH = 16,
    parameter int WAIT_STATES  = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             cpu_addr_in,
    input  logic [31:0]             cpu_data_in,
    input  logic [3:0]              cpu_wb_in,
    input  logic [2:0]              cpu_data_mode_in,
    output logic [31:0]             cpu_data_out,
    output logic                    cpu_stall_out,
    output logic                    mem_en_out,
    output logic [3:0]              mem_wb_out,
    output logic [MEMORY_WIDTH-3:0] mem_addr_out,
    output logic [31:0]             mem_data_out,
    input  logic [31:0]             mem_data_in,
    output logic                    err_out
);

    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_STATES);

    // ------------------------------------------------------------------
    // Decode of the access currently presented by the core
    // ------------------------------------------------------------------
    logic [1:0] w_size;
    logic       w_is_write;
    logic       w_misalign;
    logic       w_out_of_range;
    logic       w_err;

    assign w_size     = cpu_data_mode_in[1:0];
    assign w_is_write = |cpu_wb_in;
    // w_size[1] covers both the word code and the reserved code.
    assign w_misalign = ((w_size == SZ_HALF) && cpu_addr_in[0]) ||
                        (w_size[1] && (cpu_addr_in[1:0] != 2'b00));

    generate
        if (MEMORY_WIDTH < 32) begin : g_range_chk
            assign w_out_of_range = |cpu_addr_in[31:MEMORY_WIDTH];
        end else begin : g_full_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_err = w_misalign | w_out_of_range;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic [1:0]              r_addr_lo;
    logic                    r_is_read;
    logic                    r_err_acc;
    logic                    r_bypass;
    logic                    r_stall;
    logic [31:0]             r_data_out;
    logic                    r_mem_en;
    logic [3:0]              r_mem_wb;
    logic [MEMORY_WIDTH-3:0] r_mem_addr;
    logic [31:0]             r_mem_data;
    logic                    r_err;

    logic [31:0] w_aligned;
    logic        w_done;

    mem_lane_align u_align (
        .word        (mem_data_in),
        .size        (r_size),
        .addr_lo     (r_addr_lo),
        .is_unsigned (r_uns),
        .result      (w_aligned)
    );

    // Last stalled cycle of the current access.
    assign w_done = ((r_state == ISSUE) && (r_cnt == 4'd0)) ||
                    ((r_state == WAIT)  && (r_cnt == 4'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_size     <= SZ_BYTE;
            r_uns      <= 1'b0;
            r_addr_lo  <= 2'b00;
            r_is_read  <= 1'b0;
            r_err_acc  <= 1'b0;
            r_bypass   <= 1'b0;
            r_stall    <= 1'b0;
            r_data_out <= 32'h0000_0000;
            r_mem_en   <= 1'b0;
            r_mem_wb   <= 4'b0000;
            r_mem_addr <= '0;
            r_mem_data <= 32'h0000_0000;
            r_err      <= 1'b0;
        end else begin
            // With no wait states the RAM word only arrives in the first
            // unstalled cycle; it is shown through combinationally for that
            // cycle and captured here on the following edge.
            if (r_bypass) begin
                r_data_out <= w_aligned;
                r_bypass   <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_size     <= w_size;
                    r_uns      <= cpu_data_mode_in[2];
                    r_addr_lo  <= cpu_addr_in[1:0];
                    r_is_read  <= ~w_is_write;
                    r_err_acc  <= w_err;
                    r_mem_en   <= ~w_err;
                    r_mem_wb   <= (w_is_write && !w_err) ?
                                  lane_mask(w_size, cpu_addr_in[1:0]) : 4'b0000;
                    r_mem_addr <= cpu_addr_in[MEMORY_WIDTH-1:2];
                    r_mem_data <= replicate(w_size, cpu_data_in);
                    if (w_err) begin
                        r_err <= 1'b1;
                    end
                    r_cnt   <= C_WAIT_INIT;
                    r_stall <= 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_mem_wb <= 4'b0000;
                    if (r_cnt != 4'd0) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_done) begin
                r_state <= IDLE;
                r_stall <= 1'b0;
                if (r_is_read) begin
                    if (r_err_acc) begin
                        r_data_out <= 32'h0000_0000;
                    end else if (r_state == WAIT) begin
                        // RAM output has held since the cycle after ISSUE.
                        r_data_out <= w_aligned;
                    end else begin
                        r_bypass <= 1'b1;
                    end
                end
            end
        end
    end

    assign cpu_data_out  = r_bypass ? w_aligned : r_data_out;
    assign cpu_stall_out = r_stall;
    assign mem_en_out    = r_mem_en;
    assign mem_wb_out    = r_mem_wb;
    assign mem_addr_out  = r_mem_addr;
    assign mem_data_out  = r_mem_data;
    assign err_out       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge_rv32e.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bridge_rv32e
// Purpose  : Self-checking bench for mem_bridge_rv32e (WAIT_STATES=2,
//            MEMORY_WIDTH=16). A byte-addressed reference memory predicts
//            RAM-side strobes/data, stall length, read results and the
//            sticky error flag. A simple synchronous RAM model sits on the
//            DUT's memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bridge_rv32e;

    localparam int MW = 16;
    localparam int WS = 2;

    logic          clk;
    logic          rst_n;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_wb;
    logic [2:0]    cpu_mode;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          mem_en;
    logic [3:0]    mem_wb;
    logic [MW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state
    logic [7:0]  ref_mem [65536];
    logic [31:0] ref_dout;
    logic        ref_err;

    // Scratchpad RAM seen by the DUT
    logic [31:0] ram [16384];

    mem_bridge_rv32e #(
        .MEMORY_WIDTH (MW),
        .WAIT_STATES  (WS)
    ) dut (
        .clock            (clk),
        .reset            (rst_n),
        .cpu_addr_in      (cpu_addr),
        .cpu_data_in      (cpu_wdata),
        .cpu_wb_in        (cpu_wb),
        .cpu_data_mode_in (cpu_mode),
        .cpu_data_out     (cpu_rdata),
        .cpu_stall_out    (cpu_stall),
        .mem_en_out       (mem_en),
        .mem_wb_out       (mem_wb),
        .mem_addr_out     (mem_addr),
        .mem_data_out     (mem_wdata),
        .mem_data_in      (mem_rdata),
        .err_out          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wb[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] mode);
        if (mode[1:0] == 2'b00) return 1;
        if (mode[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_bad(input logic [31:0] a, input logic [2:0] mode);
        int nb = nbytes(mode);
        return (a >= 32'h0001_0000) || ((a % nb) != 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a,
                                               input logic [2:0]  mode);
        int     nb = nbytes(mode);
        longint v  = 0;
        for (int k = 0; k < nb; k++) begin
            v = v + (longint'(ref_mem[32'(a[15:0]) + k]) << (8 * k));
        end
        if (!mode[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) begin
            v = v - (longint'(1) << (8 * nb));
        end
        return v[31:0];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] mode);
        int nb = nbytes(mode);
        for (int k = 0; k < nb; k++) begin
            ref_mem[32'(a[15:0]) + k] = 8'((d >> (8 * k)) & 32'hFF);
        end
    endtask

    // Present one access in an unstalled cycle and follow it to completion.
    task automatic do_access(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] wb, input logic [2:0] mode);
        int          nb    = nbytes(mode);
        bit          bad   = is_bad(a, mode);
        bit          wr    = (wb != 4'b0000);
        logic [3:0]  e_wb  = 4'b0000;
        logic [31:0] e_dat = d;
        int          n;

        if (wr && !bad) e_wb = 4'(((1 << nb) - 1) << a[1:0]);
        if (nb == 1) e_dat = 32'(d[7:0]) * 32'h0101_0101;
        if (nb == 2) e_dat = 32'(d[15:0]) * 32'h0001_0001;

        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wb    = wb;
        cpu_mode  = mode;
        @(posedge clk); #1;

        if (bad) ref_err = 1'b1;
        check_val("issue_stall", 32'(cpu_stall), 32'd1);
        check_val("issue_en", 32'(mem_en), 32'(!bad));
        check_val("issue_wb", 32'(mem_wb), 32'(e_wb));
        if (!bad) begin
            check_val("issue_addr", 32'(mem_addr), a >> 2);
            if (wr) check_val("issue_wdata", mem_wdata, e_dat);
        end
        check_val("issue_err", 32'(err), 32'(ref_err));

        if (wr && !bad) model_write(a, d, mode);
        if (!wr) ref_dout = bad ? 32'h0 : model_read(a, mode);

        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!cpu_stall) break;
            n++;
            check_val("wait_en", 32'(mem_en), 32'd0);
        end
        check_val("stall_len", 32'(n), 32'(1 + WS));
        check_val("rdata", cpu_rdata, ref_dout);
        check_val("err_after", 32'(err), 32'(ref_err));
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_stall"}, 32'(cpu_stall), 32'd0);
        check_val({tag, "_en"}, 32'(mem_en), 32'd0);
        check_val({tag, "_wb"}, 32'(mem_wb), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
        check_val({tag, "_rdata"}, cpu_rdata, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_wb    = 4'h0;
        cpu_mode  = 3'b010;
        mem_rdata = 32'h0;
        ref_dout  = 32'h0;
        ref_err   = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;

        @(negedge clk);
        check_reset_state("reset");
        check_val("reset_addr", 32'(mem_addr), 32'd0);
        check_val("reset_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word write, byte/half reads with both extensions, half write
        do_access(32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010);
        do_access(32'h13, 32'h0, 4'h0, 3'b000);
        do_access(32'h13, 32'h0, 4'h0, 3'b100);
        do_access(32'h10, 32'h0, 4'h0, 3'b001);
        do_access(32'h12, 32'h0000_ABCD, 4'h3, 3'b001);
        do_access(32'h10, 32'h0, 4'h0, 3'b011);

        // Misaligned word read, out-of-range read, then a legal read
        do_access(32'h11, 32'h0, 4'h0, 3'b010);
        do_access(32'h0001_0000, 32'h0, 4'h0, 3'b000);
        do_access(32'h12, 32'h0, 4'h0, 3'b101);

        // Reset asserted in WAIT
        cpu_addr = 32'h10; cpu_wdata = 32'h0; cpu_wb = 4'h0; cpu_mode = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_wait");
        ref_err  = 1'b0;
        ref_dout = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(32'h10, 32'h0, 4'h0, 3'b010);

        // Reset asserted in ISSUE of a write: the write must not land
        cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678; cpu_wb = 4'hF; cpu_mode = 3'b010;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_issue");
        ref_err  = 1'b0;
        ref_dout = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(32'h20, 32'h0, 4'h0, 3'b010);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            logic [3:0]  wb;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 63));
            wb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_access(a, $urandom, wb, 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
